branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
//
// PURPOSE
//   Direct-mapped BTB with 2-bit saturating direction counters. Sits in IF:
//   indexed by the fetch PC, it produces the taken guess and target that the
//   PC-select encoder consumes (guess-in-IF). It is trained by the branch or
//   jump resolved in EX. It also keeps update and mispredict statistics for
//   the debug bus.
//
// PARAMETERS
//   IDX_W   4    index bits; ENTRIES = 2**IDX_W
//   ADDR_W  32   PC / target width
//
// PORTS
//   clk            in   1       system clock, rising edge
//   rstn           in   1       synchronous reset, active low
//   pc_if          in   ADDR_W  PC of the instruction in IF
//   jump_guess_if  out  1       predicted taken for pc_if (combinational)
//   target_if      out  ADDR_W  predicted target for pc_if (combinational)
//   upd_en         in   1       EX holds a resolved branch/jal/jalr this cycle
//   pc_ex          in   ADDR_W  PC of the EX instruction
//   jump_ex        in   1       EX actual outcome: taken
//   target_ex      in   ADDR_W  EX actual target
//   jump_guess_ex  in   1       guess made for this instr, piped IF->EX
//   upd_cnt        out  32      resolved control transfers counted
//   mispred_cnt    out  32      mispredictions counted
//
// BEHAVIOUR
//   - Entry i holds: valid, tag[ADDR_W-IDX_W-3:0], target[ADDR_W-1:0], ctr[1:0].
//   - Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
//   - Lookup, 0 cycles, pure combinational:
//       hit = valid & (tag == pc_if tag).
//       jump_guess_if = hit & ctr[1].
//       target_if = entry target when hit, else 0.
//   - Update at the clk edge when upd_en=1:
//     * tag hit: ctr saturates. If jump_ex, ctr++ up to 2'b11; else ctr-- down
//       to 2'b00. If jump_ex, target <= target_ex. Not taken leaves target as is.
//     * miss, jump_ex=1: allocate and overwrite the entry. valid<=1, tag<=pc_ex
//       tag, target<=target_ex, ctr<=2'b10 (weakly taken).
//     * miss, jump_ex=0: no table change.
//   - Counters, at the clk edge:
//     * upd_en=1: upd_cnt += 1.
//     * upd_en=1 and jump_guess_ex != jump_ex: mispred_cnt += 1.
//     * Both wrap 2^32-1 -> 0.
//   - Same-cycle read/write to one index: the IF lookup sees the pre-update
//     entry. There is no bypass. The new value is visible from the next cycle.
//   - Reset: rstn=0 at a clk edge clears every valid bit, sets every ctr to
//     2'b01, and zeroes upd_cnt and mispred_cnt. Tags and targets are don't-care.
//     While rstn=0, jump_guess_if=0 and target_if=0. An upd_en during reset is
//     dropped.
//   - No stall input. EX presents each resolved instruction exactly once;
//     stall gating upstream is the caller's job.
//   - One write port only. Single-cycle lookup, single-cycle update.
//
// TESTING
//   1 Reset, then pc_if=0x100 -> jump_guess_if=0, target_if=0. All counters 0.
//   2 upd_en, pc_ex=0x100, jump_ex=1, target_ex=0x80. Next cycle pc_if=0x100
//     -> guess=1, target_if=0x80. pc_if=0x140 (same index, other tag) -> guess=0.
//   3 Two not-taken updates at 0x100 -> ctr 10->01->00, guess=0.
//     Three taken updates -> ctr 11, guess=1. A fourth taken stays at 11.
//   4 Update at 0x100 while pc_if=0x100 in the same cycle -> the old guess is
//     shown that cycle and the new one the next cycle.
//   5 Ten updates, jump_guess_ex != jump_ex on 3 of them -> upd_cnt=10,
//     mispred_cnt=3. Force upd_cnt=0xFFFFFFFF and update -> upd_cnt=0.
//   6 Trained entry, then rstn=0 for 1 cycle while upd_en=1 -> entry invalid,
//     counters 0, no allocation from the dropped update.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters: combinational
// lookup for the fetch PC, single-port training from the resolved EX transfer.
module branch_predictor #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_if,
    output logic              jump_guess_if,
    output logic [ADDR_W-1:0] target_if,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] pc_ex,
    input  logic              jump_ex,
    input  logic [ADDR_W-1:0] target_ex,
    input  logic              jump_guess_ex,
    output logic [31:0]       upd_cnt,
    output logic [31:0]       mispred_cnt
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag;
    logic [ENTRIES-1:0][ADDR_W-1:0] target;
    logic [ENTRIES-1:0][1:0]        ctr;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             unused_pc_lsb;

    assign if_idx = pc_if[IDX_W+1:2];
    assign if_tag = pc_if[ADDR_W-1:IDX_W+2];
    assign ex_idx = pc_ex[IDX_W+1:2];
    assign ex_tag = pc_ex[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsb = ^{pc_if[1:0], pc_ex[1:0]};

    // Lookup reads the pre-update entry; outputs are forced quiet during reset.
    assign if_hit        = rstn & valid[if_idx] & (tag[if_idx] == if_tag);
    assign jump_guess_if = if_hit & ctr[if_idx][1];
    assign target_if     = if_hit ? target[if_idx] : '0;

    assign ex_hit = valid[ex_idx] & (tag[ex_idx] == ex_tag);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid <= '0;
            ctr   <= {ENTRIES{2'b01}};
        end else if (upd_en) begin
            if (ex_hit) begin
                if (jump_ex) begin
                    if (ctr[ex_idx] != 2'b11) ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                    target[ex_idx] <= target_ex;
                end else if (ctr[ex_idx] != 2'b00) begin
                    ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
                end
            end else if (jump_ex) begin
                // A taken miss evicts whatever alias held this slot.
                valid[ex_idx]  <= 1'b1;
                tag[ex_idx]    <= ex_tag;
                target[ex_idx] <= target_ex;
                ctr[ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            upd_cnt     <= '0;
            mispred_cnt <= '0;
        end else if (upd_en) begin
            upd_cnt <= upd_cnt + 32'd1;
            if (jump_guess_ex != jump_ex) mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: stimulus queues expected lookups/counters, a negedge
// monitor drains the queue against the live DUT outputs.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_if;
    logic        jump_guess_if;
    logic [31:0] target_if;
    logic        upd_en;
    logic [31:0] pc_ex;
    logic        jump_ex;
    logic [31:0] target_ex;
    logic        jump_guess_ex;
    logic [31:0] upd_cnt;
    logic [31:0] mispred_cnt;

    branch_predictor #(.IDX_W(4), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn), .pc_if(pc_if), .jump_guess_if(jump_guess_if),
        .target_if(target_if), .upd_en(upd_en), .pc_ex(pc_ex), .jump_ex(jump_ex),
        .target_ex(target_ex), .jump_guess_ex(jump_guess_ex),
        .upd_cnt(upd_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          is_cnt;
        logic        g;
        logic [31:0] t;
        logic [31:0] u;
        logic [31:0] m;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic drive(input logic r, input logic u, input logic [31:0] pi,
                         input logic [31:0] pe, input logic je,
                         input logic [31:0] te, input logic jg);
        rstn = r; upd_en = u; pc_if = pi; pc_ex = pe;
        jump_ex = je; target_ex = te; jump_guess_ex = jg;
    endtask

    task automatic exp_look(input string nm, input logic g, input logic [31:0] t);
        exp_t e;
        e.nm = nm; e.is_cnt = 1'b0; e.g = g; e.t = t; e.u = '0; e.m = '0;
        q.push_back(e);
    endtask

    task automatic exp_cnt(input string nm, input logic [31:0] u, input logic [31:0] m);
        exp_t e;
        e.nm = nm; e.is_cnt = 1'b1; e.g = 1'b0; e.t = '0; e.u = u; e.m = m;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (!e.is_cnt) begin
                if (jump_guess_if !== e.g || target_if !== e.t) begin
                    bad++;
                    $display("FAIL %s: got guess=%0b target=%h, want guess=%0b target=%h",
                             e.nm, jump_guess_if, target_if, e.g, e.t);
                end
            end else begin
                if (upd_cnt !== e.u || mispred_cnt !== e.m) begin
                    bad++;
                    $display("FAIL %s: got upd=%0d mispred=%0d, want upd=%0d mispred=%0d",
                             e.nm, upd_cnt, mispred_cnt, e.u, e.m);
                end
            end
        end
    end

    initial begin
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        tick();

        // reset gating and post-reset state
        drive(0, 1, 32'h100, 32'h100, 1, 32'h80, 0); exp_look("rst_gate", 0, 0); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("t1_lookup", 0, 0); exp_cnt("t1_cnt", 0, 0); tick();

        // allocation and tag aliasing
        drive(1, 1, 32'h200, 32'h100, 1, 32'h80, 0); exp_look("t2_other", 0, 0); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("t2_hit", 1, 32'h80); exp_cnt("t2_cnt", 1, 1); tick();
        drive(1, 0, 32'h140, 0, 0, 0, 0); exp_look("t2_alias", 0, 0); tick();
        drive(1, 0, 32'h103, 0, 0, 0, 0); exp_look("t2_lowbits", 1, 32'h80); tick();

        // counter walk; first cycle also checks same-cycle read shows old entry
        drive(1, 1, 32'h100, 32'h100, 0, 0, 1); exp_look("t4_same_cyc", 1, 32'h80); tick();
        drive(1, 1, 32'h100, 32'h100, 0, 0, 0); exp_look("t4_next_cyc", 0, 32'h80); exp_cnt("t3_cnt_a", 2, 2); tick();
        drive(1, 1, 32'h100, 32'h100, 0, 0, 0); exp_look("t3_ctr00", 0, 32'h80); tick();
        drive(1, 1, 32'h100, 32'h100, 1, 32'h80, 0); exp_look("t3_sat_lo", 0, 32'h80); tick();
        drive(1, 1, 32'h100, 32'h100, 1, 32'h80, 0); exp_look("t3_ctr01", 0, 32'h80); tick();
        drive(1, 1, 32'h100, 32'h100, 1, 32'h80, 1); exp_look("t3_ctr10", 1, 32'h80); tick();
        drive(1, 1, 32'h100, 32'h100, 1, 32'h90, 1); exp_look("t3_ctr11", 1, 32'h80); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("t3_sat_hi", 1, 32'h90); exp_cnt("t3_cnt_b", 8, 4); tick();

        // not-taken miss must not allocate; taken miss evicts the alias
        drive(1, 1, 32'h204, 32'h204, 0, 0, 0); exp_look("miss_nt_same", 0, 0); tick();
        drive(1, 0, 32'h204, 0, 0, 0, 0); exp_look("miss_nt_noalloc", 0, 0); tick();
        drive(1, 1, 32'h100, 32'h140, 1, 32'h44, 1); exp_look("pre_overwrite", 1, 32'h90); tick();
        drive(1, 0, 32'h140, 0, 0, 0, 0); exp_look("alloc_new", 1, 32'h44); exp_cnt("cnt_c", 10, 4); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("evicted", 0, 0); tick();

        // statistics: ten updates, three mispredicted
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 32'h300, 32'h300, 0, 0, (i == 2 || i == 5 || i == 9));
            tick();
        end
        drive(1, 0, 32'h300, 0, 0, 0, 0); exp_cnt("t5_cnt", 10, 3); exp_look("t5_noalloc", 0, 0); tick();

        // wrap of upd_cnt
        force dut.upd_cnt = 32'hFFFF_FFFF;
        drive(1, 1, 32'h300, 32'h300, 0, 0, 0);
        #1 release dut.upd_cnt;
        tick();
        drive(1, 0, 32'h300, 0, 0, 0, 0); exp_cnt("t5_wrap", 0, 3); tick();

        // reset with a concurrent update that must be dropped
        drive(1, 1, 32'h100, 32'h100, 1, 32'h80, 0); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("t6_trained", 1, 32'h80); tick();
        drive(0, 1, 32'h100, 32'h208, 1, 32'h55, 0); exp_look("t6_rst_gate", 0, 0); tick();
        drive(1, 0, 32'h100, 0, 0, 0, 0); exp_look("t6_invalid", 0, 0); exp_cnt("t6_cnt", 0, 0); tick();
        drive(1, 0, 32'h208, 0, 0, 0, 0); exp_look("t6_dropped", 0, 0); tick();

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
